// File: rtl/shift_add_accum.sv
// Bit-serial shift-and-add accumulator for per-column ADC codes.
// A job accumulates n_bits bit-planes (MSB plane first) per column, then
// presents a shifted, saturated signed result with a valid/ready handshake.
module shift_add_accum #(
    parameter int numCols      = 32,
    parameter int adcBits      = 4,
    parameter int maxInputBits = 8,
    parameter int accBits      = 16,
    parameter int outBits      = 8
) (
    input  logic                              clk,
    input  logic                              nrst,
    input  logic                              mac_valid_i,
    output logic                              ready_o,
    input  logic [$clog2(maxInputBits):0]     cfg_n_bits_i,
    input  logic                              cfg_signed_i,
    input  logic                              cfg_bipolar_i,
    input  logic [$clog2(accBits)-1:0]        cfg_shift_i,
    input  logic                              adc_valid_i,
    input  logic [numCols*adcBits-1:0]        adc_data_i,
    output logic [$clog2(maxInputBits)-1:0]   bit_idx_o,
    output logic                              busy_o,
    output logic                              valid_o,
    input  logic                              ready_i,
    output logic [numCols*outBits-1:0]        mac_data_o
);

    localparam int NBW  = $clog2(maxInputBits) + 1;
    localparam int IDXW = $clog2(maxInputBits);
    localparam int SHW  = $clog2(accBits);

    localparam logic signed [accBits-1:0] SAT_MAX  = accBits'((2 ** (outBits - 1)) - 1);
    localparam logic signed [accBits-1:0] SAT_MIN  = accBits'(-(2 ** (outBits - 1)));
    localparam logic signed [accBits-1:0] ADC_BIAS = accBits'(2 ** (adcBits - 1));

    // The accumulator must hold the full unsaturated sum of every plane.
    if (accBits < adcBits + maxInputBits + 1) begin : g_acc_width_check
        $error("shift_add_accum: accBits too small for adcBits+maxInputBits+1");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    state_t                     state_q;
    state_t                     state_d;
    logic                       init_q;
    logic [IDXW-1:0]            cnt_q;
    logic                       first_q;
    logic                       signed_q;
    logic                       bipolar_q;
    logic [SHW-1:0]             shift_q;

    logic signed [accBits-1:0]  acc_p0  [numCols];
    logic signed [accBits-1:0]  acc_nxt [numCols];
    logic signed [outBits-1:0]  res_p1  [numCols];
    logic signed [outBits-1:0]  res_nxt [numCols];

    logic                       accept;
    logic                       plane_go;
    logic                       last_plane;

    // Zero planes means one; anything beyond the maximum is clamped.
    function automatic logic [IDXW-1:0] first_cnt(input logic [NBW-1:0] n);
        logic [NBW-1:0] nb;
        if (n == '0)
            nb = NBW'(1);
        else if (n > NBW'(maxInputBits))
            nb = NBW'(maxInputBits);
        else
            nb = n;
        return IDXW'(nb - NBW'(1));
    endfunction

    // Partial sum of one column for one plane, negated for the sign plane.
    function automatic logic signed [accBits-1:0] plane_term(
        input logic [adcBits-1:0] code,
        input logic               bip,
        input logic               neg
    );
        logic signed [accBits-1:0] ps;
        ps = $signed({{(accBits - adcBits){1'b0}}, code});
        if (bip)
            ps = ps - ADC_BIAS;
        return neg ? -ps : ps;
    endfunction

    // Clamp the shifted accumulator into the signed output range.
    function automatic logic signed [outBits-1:0] sat_out(input logic signed [accBits-1:0] v);
        if (v > SAT_MAX)
            return SAT_MAX[outBits-1:0];
        else if (v < SAT_MIN)
            return SAT_MIN[outBits-1:0];
        else
            return v[outBits-1:0];
    endfunction

    assign accept     = mac_valid_i & ready_o;
    assign plane_go   = (state_q == ACCUM) & adc_valid_i;
    assign last_plane = plane_go & (cnt_q == '0);

    assign ready_o   = init_q & (state_q == IDLE);
    assign busy_o    = (state_q == ACCUM) | (state_q == OUTPUT);
    assign valid_o   = (state_q == OUTPUT);
    assign bit_idx_o = (state_q == ACCUM) ? cnt_q : '0;

    // Next accumulator value and the result it would produce, per column.
    always_comb begin
        for (int k = 0; k < numCols; k++) begin
            acc_nxt[k] = (acc_p0[k] <<< 1)
                       + plane_term(adc_data_i[k*adcBits +: adcBits], bipolar_q, signed_q & first_q);
            res_nxt[k] = sat_out(acc_nxt[k] >>> shift_q);
        end
    end

    // Pack the registered per-column results onto the output bus.
    always_comb begin
        mac_data_o = '0;
        for (int k = 0; k < numCols; k++)
            mac_data_o[k*outBits +: outBits] = res_p1[k];
    end

    // Ready is held low until the first clock after reset release.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            init_q <= 1'b0;
        else
            init_q <= 1'b1;
    end

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic: job accept, last plane consumed, result taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)     state_d = ACCUM;
            ACCUM:   if (last_plane) state_d = OUTPUT;
            OUTPUT:  if (ready_i)    state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // Stage 0: job configuration, plane counter and accumulators.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q     <= '0;
            first_q   <= 1'b0;
            signed_q  <= 1'b0;
            bipolar_q <= 1'b0;
            shift_q   <= '0;
            for (int k = 0; k < numCols; k++)
                acc_p0[k] <= '0;
        end else if (accept) begin
            cnt_q     <= first_cnt(cfg_n_bits_i);
            first_q   <= 1'b1;
            signed_q  <= cfg_signed_i;
            bipolar_q <= cfg_bipolar_i;
            shift_q   <= cfg_shift_i;
            for (int k = 0; k < numCols; k++)
                acc_p0[k] <= '0;
        end else if (plane_go) begin
            first_q <= 1'b0;
            if (cnt_q != '0)
                cnt_q <= cnt_q - IDXW'(1);
            for (int k = 0; k < numCols; k++)
                acc_p0[k] <= acc_nxt[k];
        end
    end

    // Stage 1: result register, loaded as the last plane is consumed.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int k = 0; k < numCols; k++)
                res_p1[k] <= '0;
        end else if (last_plane) begin
            for (int k = 0; k < numCols; k++)
                res_p1[k] <= res_nxt[k];
        end
    end

endmodule
